// File: rtl/fft_stage_pipe.sv
// fft_stage_pipe: LANES parallel radix-2 butterflies (y0 = a + b*tw, y1 = a - b*tw) in a 3-stage elastic pipeline.
// Build option: define FFT_STAGE_ROUND_EN to round the product realignment half-up instead of truncating.
module fft_stage_pipe #(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*N-1:0] a_r,
    input  logic [LANES*N-1:0] a_i,
    input  logic [LANES*N-1:0] b_r,
    input  logic [LANES*N-1:0] b_i,
    input  logic [LANES*N-1:0] tw_r,
    input  logic [LANES*N-1:0] tw_i,
    input  logic               scale,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] y0_r,
    output logic [LANES*N-1:0] y0_i,
    output logic [LANES*N-1:0] y1_r,
    output logic [LANES*N-1:0] y1_i,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int PW = 2 * N + 1;
    localparam int W  = N + 2;

`ifdef FFT_STAGE_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (Q - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    localparam logic signed [W-1:0] SAT_HI = W'((64'sd1 <<< (N - 1)) - 64'sd1);
    localparam logic signed [W-1:0] SAT_LO = ~SAT_HI;

    // Returns {saturated, clamped value}.
    function automatic logic [N:0] saturate(input logic signed [W-1:0] v);
        if (v > SAT_HI)
            return {1'b1, SAT_HI[N-1:0]};
        else if (v < SAT_LO)
            return {1'b1, SAT_LO[N-1:0]};
        else
            return {1'b0, v[N-1:0]};
    endfunction

    function automatic logic signed [W-1:0] scale_down(input logic signed [W-1:0] v,
                                                      input logic s);
        return s ? (v >>> 1) : v;
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic s1_v;
    logic s2_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (en) begin
            s1_v <= in_valid;
            s2_v <= s1_v;
        end
    end

    logic [LANES*N-1:0] s1_a_r;
    logic [LANES*N-1:0] s1_a_i;
    logic [LANES*N-1:0] s1_b_r;
    logic [LANES*N-1:0] s1_b_i;
    logic [LANES*N-1:0] s1_tw_r;
    logic [LANES*N-1:0] s1_tw_i;
    logic               s1_scale;

    logic [LANES*N-1:0] s2_a_r;
    logic [LANES*N-1:0] s2_a_i;
    logic [LANES*W-1:0] s2_p_r;
    logic [LANES*W-1:0] s2_p_i;
    logic               s2_scale;

    logic [LANES*W-1:0] p_r_next;
    logic [LANES*W-1:0] p_i_next;

    // Data stages carry no reset; the valid shift register decides what is observable.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_a_r   <= a_r;
            s1_a_i   <= a_i;
            s1_b_r   <= b_r;
            s1_b_i   <= b_i;
            s1_tw_r  <= tw_r;
            s1_tw_i  <= tw_i;
            s1_scale <= scale;
            s2_a_r   <= s1_a_r;
            s2_a_i   <= s1_a_i;
            s2_p_r   <= p_r_next;
            s2_p_i   <= p_i_next;
            s2_scale <= s1_scale;
        end
    end

    logic [LANES*N-1:0] y0_r_next;
    logic [LANES*N-1:0] y0_i_next;
    logic [LANES*N-1:0] y1_r_next;
    logic [LANES*N-1:0] y1_i_next;
    logic [LANES-1:0]   lane_sat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [N-1:0]  br;
        logic signed [N-1:0]  bi;
        logic signed [N-1:0]  twr;
        logic signed [N-1:0]  twi;
        logic signed [PW-1:0] full_r;
        logic signed [PW-1:0] full_i;
        logic signed [N-1:0]  ar;
        logic signed [N-1:0]  ai;
        logic signed [W-1:0]  pr;
        logic signed [W-1:0]  pi;
        logic signed [W-1:0]  sum0_r;
        logic signed [W-1:0]  sum0_i;
        logic signed [W-1:0]  sum1_r;
        logic signed [W-1:0]  sum1_i;
        logic [3:0]           sat;

        assign br  = s1_b_r[k*N +: N];
        assign bi  = s1_b_i[k*N +: N];
        assign twr = s1_tw_r[k*N +: N];
        assign twi = s1_tw_i[k*N +: N];

        // Complex product kept one bit wider than 2N so the cross-term sum cannot wrap.
        assign full_r = PW'(br) * PW'(twr) - PW'(bi) * PW'(twi);
        assign full_i = PW'(br) * PW'(twi) + PW'(bi) * PW'(twr);

        assign p_r_next[k*W +: W] = W'((full_r + RND) >>> Q);
        assign p_i_next[k*W +: W] = W'((full_i + RND) >>> Q);

        assign ar = s2_a_r[k*N +: N];
        assign ai = s2_a_i[k*N +: N];
        assign pr = s2_p_r[k*W +: W];
        assign pi = s2_p_i[k*W +: W];

        assign sum0_r = scale_down(W'(ar) + pr, s2_scale);
        assign sum0_i = scale_down(W'(ai) + pi, s2_scale);
        assign sum1_r = scale_down(W'(ar) - pr, s2_scale);
        assign sum1_i = scale_down(W'(ai) - pi, s2_scale);

        assign {sat[0], y0_r_next[k*N +: N]} = saturate(sum0_r);
        assign {sat[1], y0_i_next[k*N +: N]} = saturate(sum0_i);
        assign {sat[2], y1_r_next[k*N +: N]} = saturate(sum1_r);
        assign {sat[3], y1_i_next[k*N +: N]} = saturate(sum1_i);

        assign lane_sat[k] = |sat;
    end

    // Output stage; a saturation set beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y0_r      <= '0;
            y0_i      <= '0;
            y1_r      <= '0;
            y1_i      <= '0;
            ovf       <= 1'b0;
        end else begin
            if (en) begin
                out_valid <= s2_v;
                y0_r      <= y0_r_next;
                y0_i      <= y0_i_next;
                y1_r      <= y1_r_next;
                y1_i      <= y1_i_next;
            end
            if (en && s2_v && (|lane_sat))
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: doc/fft_stage_pipe.md
FFT_STAGE_PIPE -- requirements
Module: fft_stage_pipe

Interface
REQ-001 Parameter N, default 16: sample word width in bits, two's complement.
REQ-002 Parameter Q, default 8: fractional bits of data and twiddles.
REQ-003 Parameter LANES, default 4: radix-2 butterflies evaluated per beat.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid / in_ready  input / output  1 / 1  input beat handshake.
REQ-007 a_r, a_i, b_r, b_i  input  LANES*N each  top (a) and bottom (b) operands; lane k occupies bits [k*N +: N].
REQ-008 tw_r, tw_i  input  LANES*N each  per-lane twiddle, sampled with the beat.
REQ-009 scale  input  1  when 1, both outputs of the beat are arithmetically shifted right by 1; sampled with the beat.
REQ-010 out_valid / out_ready  output / input  1 / 1  output beat handshake.
REQ-011 y0_r, y0_i, y1_r, y1_i  output  LANES*N each  per-lane results, same lane packing as the inputs.
REQ-012 ovf  output  1  sticky saturation flag.
REQ-013 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-014 Per lane: p = b*tw (complex); y0 = a + p; y1 = a - p.
REQ-015 Products are formed at 2N bits, realigned by >>Q (arithmetic), then held at N+2 bits through the add/subtract.
REQ-016 When scale=1, the N+2-bit sum is shifted right by 1 (arithmetic) before saturation.
REQ-017 Each output component saturates to [-2^(N-1), 2^(N-1)-1].
REQ-018 Pipeline: 3 register stages (S1 input capture, S2 product, S3 add/sub/saturate); latency is exactly 3 cycles from the in_valid&&in_ready edge to out_valid with no backpressure.
REQ-019 Global advance enable en = !out_valid || out_ready; in_ready = en, combinational from out_ready and the stage-3 valid only.
REQ-020 When en=0, all stage data and valid bits hold; no beat is lost or duplicated.
REQ-021 Stage valids are a 3-bit shift register advanced by en; bubbles propagate as invalid stages.
REQ-022 out_valid and y* are registered outputs; y* stay stable while out_valid=1 and out_ready=0.
REQ-023 Sustained throughput is one beat per cycle when out_ready=1.
REQ-024 ovf sets in the cycle a beat saturating any component of any lane enters S3 (with en=1).
REQ-025 ovf_clr clears ovf; when a set and a clear occur in the same cycle, the set wins.
REQ-026 Data stages carry no reset dependency beyond REQ-027; valid bits alone gate observability.

Reset
REQ-027 While rst=1: all stage valids=0, out_valid=0, y*=0, ovf=0; in_ready=1.
REQ-028 Assertion mid-operation discards all in-flight beats immediately; the first accepted beat after release emerges after 3 cycles.

Configuration
REQ-029 Macro FFT_STAGE_ROUND_EN defined: the Q-bit product realignment rounds half-up (adds 2^(Q-1) before the shift).
REQ-030 Macro FFT_STAGE_ROUND_EN undefined: the realignment truncates (floor); all other behaviour is identical.

Verification
REQ-031 N=16,Q=8, lane0 a=(1.0,0)=0x0100, b=(0.5,0)=0x0080, tw=(1.0,0), scale=0 -> after 3 cycles y0=(0x0180,0), y1=(0x0080,0).
REQ-032 a=(0x7F00,0), b=(0x7F00,0), tw=(1.0,0) -> y0_r=0x7FFF, y1_r=0x0000, ovf=1; ovf_clr pulse -> ovf=0; same-cycle saturating beat and ovf_clr -> ovf stays 1.
REQ-033 Same stimulus as REQ-032 with scale=1 -> y0_r=0x7F00, y1_r=0x0000, ovf remains 0.
REQ-034 b=(0x0001,0), tw=(0x0080,0) (0.5), a=0 -> product 0.5 LSB: y0_r=0x0001 with FFT_STAGE_ROUND_EN, 0x0000 without.
REQ-035 Stream 20 consecutive beats, out_ready toggled with a random pattern -> all 20 results emerge in order, none dropped or duplicated, y* stable during every stall.
REQ-036 Assert rst with 3 beats in flight -> out_valid=0 immediately and those beats never appear; next beat emerges 3 cycles after acceptance.
